router_pkt_tx: RTL

Packet transmitter that drives the router's input port: it builds a header byte from a destination address and payload length, streams payload bytes from a local show-ahead source, and appends an even-parity byte. It obeys the router's `busy` back-pressure and sits on the source side, upstream of the router's address detect, FIFO write enables and output FIFOs. It also aborts a packet whose transfer is stalled for too long, matching the router's own timeout-and-drop behaviour.

---
 rtl/router_pkt_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// Source-side packet transmitter for the router input port: header {len,dest}, payload
// bytes from a show-ahead source, then an even-parity byte, with busy-stall abort.
module router_pkt_tx #(
  parameter int BUSY_LIMIT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic [7:0] pld_data,
  input  logic       busy,
  output logic       pld_rd,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic       tx_busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

  localparam logic [5:0] STALL_LIMIT = 6'(BUSY_LIMIT);

  state_t      state_reg, state_next;
  logic [5:0]  rem_reg, rem_next;
  logic [7:0]  parity_reg, parity_next;
  logic [5:0]  stall_reg, stall_next;
  logic [7:0]  data_reg, data_next;
  logic        pkt_valid_reg, pkt_valid_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      rem_reg       <= '0;
      parity_reg    <= '0;
      stall_reg     <= '0;
      data_reg      <= '0;
      pkt_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rem_reg       <= rem_next;
      parity_reg    <= parity_next;
      stall_reg     <= stall_next;
      data_reg      <= data_next;
      pkt_valid_reg <= pkt_valid_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    parity_next    = parity_reg;
    stall_next     = stall_reg;
    data_next      = data_reg;
    pkt_valid_next = pkt_valid_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    pld_rd         = 1'b0;

    if (state_reg != IDLE && busy) begin
      // Stalled: everything holds; give up once the stall has lasted BUSY_LIMIT cycles
      if (stall_reg == STALL_LIMIT) begin
        pkt_valid_next = 1'b0;
        data_next      = '0;
        err_next       = 1'b1;
        stall_next     = '0;
        state_next     = IDLE;
      end else begin
        stall_next = stall_reg + 6'd1;
      end
    end else begin
      stall_next = '0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (dest != 2'd3 && len != 6'd0) begin
              data_next      = {len, dest};
              parity_next    = {len, dest};
              rem_next       = len;
              pkt_valid_next = 1'b1;
              state_next     = HEADER;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        HEADER, PAYLOAD: begin
          if (rem_reg != 6'd0) begin
            pld_rd      = 1'b1;
            data_next   = pld_data;
            parity_next = parity_reg ^ pld_data;
            rem_next    = rem_reg - 6'd1;
            state_next  = PAYLOAD;
          end else begin
            data_next      = parity_reg;
            pkt_valid_next = 1'b0;
            state_next     = PARITY;
          end
        end
        PARITY: begin
          data_next  = '0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign pkt_valid = pkt_valid_reg;
  assign data_in   = data_reg;
  assign tx_busy   = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

endmodule
